right_shift_deser: RTL and testbench

// - Serial-to-parallel receiver; the far end of the LSB-first serial stream produced by the

---
 rtl/right_shift_deser.sv | 93 +++++++++
 tb/tb_right_shift_deser.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/right_shift_deser.sv
// LSB-first serial-to-parallel receiver with a one-entry valid/ready holding register
// and a sticky overrun flag for completed words that could not be stored.
module right_shift_deser #(
   parameter int unsigned DW = 4
) (
   input  logic          clk,
   input  logic          async_rst,
   input  logic          start,
   input  logic          en,
   input  logic          din,
   output logic [DW-1:0] out_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          busy,
   output logic          overrun,
   input  logic          ovr_clr
);

   localparam int unsigned CW = (DW > 2) ? $clog2(DW) : 1;
   localparam logic [CW-1:0] LastCnt = CW'(DW - 1);

   logic [DW-1:0] r_sh;
   logic [CW-1:0] r_cnt;
   logic [DW-1:0] r_data;
   logic          r_valid;
   logic          r_ovr;

   logic [DW-1:0] w_sh_base;
   logic [CW-1:0] w_cnt_base;
   logic [DW-1:0] w_sh_d;
   logic [CW-1:0] w_cnt_d;
   logic [DW-1:0] w_word;
   logic          w_complete;
   logic          w_accept;
   logic          w_drop;
   logic          w_load;
   logic [DW-1:0] w_data_d;
   logic          w_valid_d;
   logic          w_ovr_d;

   // start clears the partial word before any shift in the same cycle
   assign w_sh_base  = start ? '0 : r_sh;
   assign w_cnt_base = start ? '0 : r_cnt;
   assign w_word     = {din, r_sh[DW-1:1]};
   assign w_complete = en & ~start & (r_cnt == LastCnt);
   assign w_accept   = r_valid & out_ready;
   assign w_load     = w_complete & (~r_valid | out_ready);
   assign w_drop     = w_complete & r_valid & ~out_ready;

   always_comb begin
      w_sh_d  = w_sh_base;
      w_cnt_d = w_cnt_base;
      if (en) begin
         w_sh_d  = {din, w_sh_base[DW-1:1]};
         w_cnt_d = w_complete ? '0 : w_cnt_base + 1'b1;
      end
   end

   always_comb begin
      w_data_d  = r_data;
      w_valid_d = r_valid;
      if (w_load) begin
         w_data_d  = w_word;
         w_valid_d = 1'b1;
      end else if (w_accept) begin
         w_valid_d = 1'b0;
      end
      // a dropped word wins over a same-cycle clear
      w_ovr_d = w_drop | (r_ovr & ~ovr_clr);
   end

   always_ff @(posedge clk or posedge async_rst) begin
      if (async_rst) begin
         r_sh    <= '0;
         r_cnt   <= '0;
         r_data  <= '0;
         r_valid <= 1'b0;
         r_ovr   <= 1'b0;
      end else begin
         r_sh    <= w_sh_d;
         r_cnt   <= w_cnt_d;
         r_data  <= w_data_d;
         r_valid <= w_valid_d;
         r_ovr   <= w_ovr_d;
      end
   end

   assign out_data  = r_data;
   assign out_valid = r_valid;
   assign busy      = (r_cnt != '0);
   assign overrun   = r_ovr;

endmodule

// File: tb/tb_right_shift_deser.sv
// Self-checking bench for right_shift_deser: directed scenarios plus random traffic,
// all checked against a bit-collecting reference model.
module tb_right_shift_deser;

   localparam int unsigned DW = 4;

   logic          clk = 1'b0;
   logic          async_rst;
   logic          start, en, din, out_ready, ovr_clr;
   logic [DW-1:0] out_data;
   logic          out_valid, busy, overrun;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   int            m_n;
   logic [DW-1:0] m_acc;
   logic [DW-1:0] m_data;
   logic          m_valid;
   logic          m_ovr;

   right_shift_deser #(.DW(DW)) u_dut (
      .clk       (clk),
      .async_rst (async_rst),
      .start     (start),
      .en        (en),
      .din       (din),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy),
      .overrun   (overrun),
      .ovr_clr   (ovr_clr)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_n = 0; m_acc = '0; m_data = '0; m_valid = 1'b0; m_ovr = 1'b0;
   endtask

   // Drive one cycle, advance the model across the edge, return 1 ns after the edge.
   task automatic step(input logic s, input logic e, input logic d, input logic r,
                       input logic c);
      logic          done;
      logic [DW-1:0] word;
      start = s; en = e; din = d; out_ready = r; ovr_clr = c;
      @(posedge clk);
      done = 1'b0;
      word = '0;
      if (s) begin m_n = 0; m_acc = '0; end
      if (e) begin
         m_acc[m_n] = d;
         m_n++;
         if (m_n == DW) begin
            done = 1'b1; word = m_acc; m_n = 0; m_acc = '0;
         end
      end
      if (done && (!m_valid || r)) begin
         m_data = word; m_valid = 1'b1;
         m_ovr  = m_ovr & ~c;
      end else if (done) begin
         m_ovr = 1'b1;
      end else begin
         if (m_valid && r) m_valid = 1'b0;
         m_ovr = m_ovr & ~c;
      end
      #1;
   endtask

   task automatic send_word(input logic [DW-1:0] w, input logic r);
      for (int i = 0; i < DW; i++) step(1'b0, 1'b1, w[i], r, 1'b0);
   endtask

   task automatic test_reset();
      n_tests++;
      if (out_data !== '0 || out_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
         n_fail++;
         $display("FAIL reset: data=%h v=%b b=%b o=%b exp all 0",
                  out_data, out_valid, busy, overrun);
      end
   endtask

   task automatic test_basic();
      logic [3:0] bits = 4'b1101;
      logic [3:0] exp_busy = 4'b0111;
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b1, bits[i], 1'b1, 1'b0);
         n_tests++;
         if (busy !== exp_busy[i] || busy !== 1'(m_n != 0)) begin
            n_fail++;
            $display("FAIL basic_busy bit%0d: got %b exp %b", i, busy, exp_busy[i]);
         end
      end
      n_tests++;
      if (out_data !== 4'hD || out_valid !== 1'b1 || m_data !== 4'hD) begin
         n_fail++;
         $display("FAIL basic_word: data=%h v=%b exp data=d v=1", out_data, out_valid);
      end
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      n_tests++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_accept: v=%b exp 0", out_valid);
      end
   endtask

   task automatic test_overrun();
      send_word(4'hD, 1'b0);
      send_word(4'h6, 1'b0);
      n_tests++;
      if (out_data !== 4'hD || out_valid !== 1'b1 || overrun !== 1'b1) begin
         n_fail++;
         $display("FAIL overrun_set: data=%h v=%b o=%b exp data=d v=1 o=1",
                  out_data, out_valid, overrun);
      end
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      n_tests++;
      if (overrun !== 1'b0 || out_data !== 4'hD || out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL overrun_clr: o=%b data=%h v=%b exp o=0 data=d v=1",
                  overrun, out_data, out_valid);
      end
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_start();
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      n_tests++;
      if (busy !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL start_restart: b=%b v=%b exp b=1 v=0", busy, out_valid);
      end
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      n_tests++;
      if (out_data !== 4'h9 || out_valid !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL start_word: data=%h v=%b b=%b exp data=9 v=1 b=0",
                  out_data, out_valid, busy);
      end
      // start alone only clears the partial count
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      n_tests++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL start_clear: b=%b exp 0", busy);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] stream = 8'h5A;
      logic [3:0] exp_w;
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'b1, stream[i], 1'b1, 1'b0);
         if (i % 4 == 3) begin
            exp_w = (i == 3) ? 4'hA : 4'h5;
            n_tests++;
            if (out_data !== exp_w || out_valid !== 1'b1 || overrun !== 1'b0) begin
               n_fail++;
               $display("FAIL b2b word%0d: data=%h v=%b o=%b exp data=%h v=1 o=0",
                        i / 4, out_data, out_valid, overrun, exp_w);
            end
         end
      end
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_gaps();
      logic [3:0] w = 4'hB;
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b1, w[i], 1'b1, 1'b0);
         for (int g = 0; g < 2; g++) begin
            step(1'b0, 1'b0, ~w[i], 1'b1, 1'b0);
            n_tests++;
            if (busy !== 1'(m_n != 0)) begin
               n_fail++;
               $display("FAIL gaps_busy bit%0d: got %b exp %b", i, busy, 1'(m_n != 0));
            end
         end
      end
      n_tests++;
      if (out_data !== 4'hB) begin
         n_fail++;
         $display("FAIL gaps_word: data=%h exp b", out_data);
      end
   endtask

   task automatic test_async_reset();
      send_word(4'h3, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      #2 async_rst = 1'b1;
      #1;
      model_reset();
      n_tests++;
      if (out_data !== '0 || out_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
         n_fail++;
         $display("FAIL async_rst: data=%h v=%b b=%b o=%b exp all 0",
                  out_data, out_valid, busy, overrun);
      end
      #2 async_rst = 1'b0;
      send_word(4'hE, 1'b1);
      n_tests++;
      if (out_data !== 4'hE || out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL async_rst_after: data=%h v=%b exp data=e v=1", out_data, out_valid);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
              ($urandom_range(0, 2) != 0), ($urandom_range(0, 7) == 0));
         n_tests++;
         if (out_data !== m_data || out_valid !== m_valid || busy !== 1'(m_n != 0) ||
             overrun !== m_ovr) begin
            n_fail++;
            $display("FAIL random cyc%0d: data=%h v=%b b=%b o=%b exp data=%h v=%b b=%b o=%b",
                     i, out_data, out_valid, busy, overrun,
                     m_data, m_valid, 1'(m_n != 0), m_ovr);
         end
      end
   endtask

   initial begin
      async_rst = 1'b1;
      start = 1'b0; en = 1'b0; din = 1'b0; out_ready = 1'b0; ovr_clr = 1'b0;
      model_reset();
      #12 async_rst = 1'b0;
      @(posedge clk);
      #1;
      test_reset();
      test_basic();
      test_overrun();
      test_start();
      test_back_to_back();
      test_gaps();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
